// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared constants and loader state encoding for the
//               instruction-memory boot loader, the instruction memory and
//               the core. Optional macro: IMEM_LOADER_CHECKSUM_EN adds the
//               trailing checksum state.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Instruction memory geometry shared with the memory and the core
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;
    localparam int INSTR_W     = 16;

    // Frame layout, in bytes
    localparam int BYTE_W      = 8;
    localparam int LEN_BYTES   = 2;
    localparam int WORD_BYTES  = INSTR_W / BYTE_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_BYTES   = 1;
`else
    localparam int CHK_BYTES   = 0;
`endif
    localparam int FRAME_OVERHEAD_BYTES = LEN_BYTES + CHK_BYTES;

    // Total bytes on the wire for an image of n_words instructions
    function automatic int frame_bytes(input int n_words);
        return FRAME_OVERHEAD_BYTES + n_words * WORD_BYTES;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CHK     = 3'd7
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time byte-stream loader for the instruction memory.
//               Parses a length-prefixed big-endian word stream, writes
//               consecutive addresses from 0 and holds the core in reset
//               until the image is complete.
//               Optional macro: IMEM_LOADER_CHECKSUM_EN appends an XOR
//               checksum byte to the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra bit so an image of exactly DEPTH words terminates without wrap
    localparam int CNT_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = ST_CHK;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_accept   = in_valid && in_ready;
    assign w_len_full = {len_hi_q, in_data};
    assign w_cnt_inc  = cnt_q + CNT_W'(1);

    // Status outputs decode directly from the state register
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERR);
    assign cpu_hold = (state_q != ST_DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    // Frame parser: next state, word assembly and write-port staging
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d     = w_accept ? (chk_q ^ in_data) : chk_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    len_d = w_len_full[CNT_W-1:0];
                    cnt_d = '0;
                    if (w_len_full == 16'd0) begin
                        state_d = END_STATE;
                    end else if (w_len_full > 16'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (w_accept) begin
                    hi_d    = in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (w_accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = {hi_q, in_data};
                    cnt_d     = w_cnt_inc;
                    state_d   = (w_cnt_inc == len_q) ? END_STATE : ST_DATA_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    state_d = (in_data == chk_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any half-assembled word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_hi_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule
`default_nettype wire
